// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and constants for the stopwatch serial command front-end:
// receiver state encoding and the ASCII command bytes it recognises.
package uart_cmd_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam logic [7:0] CMD_START_U = 8'h53;
    localparam logic [7:0] CMD_START_L = 8'h73;
    localparam logic [7:0] CMD_STOP_U  = 8'h54;
    localparam logic [7:0] CMD_STOP_L  = 8'h74;

    localparam int NUM_CMDS = 2;
    localparam int CMD_IDX_START = 0;
    localparam int CMD_IDX_STOP  = 1;

    function automatic logic is_start_cmd(input logic [7:0] b);
        return (b == CMD_START_U) || (b == CMD_START_L);
    endfunction

    function automatic logic is_stop_cmd(input logic [7:0] b);
        return (b == CMD_STOP_U) || (b == CMD_STOP_L);
    endfunction

endpackage

// File: rtl/uart_cmd_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and LSB-first
// shift register. Emits one-cycle valid / frame_err strobes.
module uart_rx_8n1
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic            sync1_q;
    logic            rx_s_q;
    rx_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            frame_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        // A start bit that has vanished by mid-bit was a glitch.
                        state_q <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line idles so a held-low line cannot retrigger.
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command front-end for the stopwatch: decodes 'S'/'s' and 'T'/'t'
// into timed active-low start/stop request pulses.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int PULSE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Rx,
    output logic       o_fStart,
    output logic       o_fStop,
    output logic [7:0] o_RxData,
    output logic       o_RxValid,
    output logic       o_FrameErr
);

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_frame_err;
    logic [NUM_CMDS-1:0] cmd_hit;
    logic [NUM_CMDS-1:0] pulse_low;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst),
        .rx_i       (i_Rx),
        .data_o     (rx_data),
        .valid_o    (rx_valid),
        .frame_err_o(rx_frame_err)
    );

    assign cmd_hit[CMD_IDX_START] = rx_valid && is_start_cmd(rx_data);
    assign cmd_hit[CMD_IDX_STOP]  = rx_valid && is_stop_cmd(rx_data);

    // The strobe cycle itself is the first low cycle, so the counter only
    // covers the remaining PULSE_CYCLES-1 clocks.
    generate
        for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_pulse
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cmd_hit[gi])       cnt_d = 8'(PULSE_CYCLES - 1);
                else if (cnt_q != '0)  cnt_d = cnt_q - 8'd1;
            end

            always_ff @(posedge i_Clk or negedge i_Rst) begin
                if (!i_Rst) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign pulse_low[gi] = cmd_hit[gi] || (cnt_q != '0);
        end
    endgenerate

    assign o_fStart   = ~pulse_low[CMD_IDX_START];
    assign o_fStop    = ~pulse_low[CMD_IDX_STOP];
    assign o_RxData   = rx_data;
    assign o_RxValid  = rx_valid;
    assign o_FrameErr = rx_frame_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx at CLKS_PER_BIT=10, PULSE_CYCLES=4.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int PULSE  = 4;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b0;
    logic       i_Rx  = 1'b1;
    logic       o_fStart;
    logic       o_fStop;
    logic [7:0] o_RxData;
    logic       o_RxValid;
    logic       o_FrameErr;

    uart_cmd_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .CLKS_PER_BIT(CPB),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Rx      (i_Rx),
        .o_fStart  (o_fStart),
        .o_fStop   (o_fStop),
        .o_RxData  (o_RxData),
        .o_RxValid (o_RxValid),
        .o_FrameErr(o_FrameErr)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         gap;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_valid_cyc = 0;
    logic [7:0] last_good = 8'h00;
    int         exp_start = 0;
    int         exp_stop = 0;
    int         start_pulses = 0;
    int         stop_pulses = 0;
    int         start_run = 0;
    int         stop_run = 0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_start(input logic [7:0] d);
        return (d == 8'h53) || (d == 8'h73);
    endfunction

    function automatic bit model_stop(input logic [7:0] d);
        return (d == 8'h54) || (d == 8'h74);
    endfunction

    task automatic drive_bit(input logic b);
        i_Rx = b;
        repeat (CPB) @(posedge i_Clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        exp_t e;
        e.data = stop ? d : last_good;
        e.err  = !stop;
        e.gap  = gap;
        sb_q.push_back(e);
        if (stop) begin
            last_good = d;
            if (model_start(d)) exp_start++;
            if (model_stop(d))  exp_stop++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        i_Rx = 1'b1;
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_fStart"},   o_fStart,   1);
        check_eq({tag, "_fStop"},    o_fStop,    1);
        check_eq({tag, "_RxData"},   o_RxData,   0);
        check_eq({tag, "_RxValid"},  o_RxValid,  0);
        check_eq({tag, "_FrameErr"}, o_FrameErr, 0);
    endtask

    // Monitor: pops scoreboard on every strobe and measures pulse widths.
    always @(negedge i_Clk) begin
        if (i_Rst) begin
            if (o_RxValid || o_FrameErr) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_strobe", 1, 0);
                end else begin
                    automatic exp_t e = sb_q.pop_front();
                    $display("strobe cyc=%0d valid=%0b ferr=%0b data=0x%02h", cyc, o_RxValid, o_FrameErr, o_RxData);
                    check_eq("strobe_kind_valid", o_RxValid, e.err ? 0 : 1);
                    check_eq("strobe_kind_ferr", o_FrameErr, e.err ? 1 : 0);
                    check_eq("rx_data", o_RxData, e.data);
                    check_eq("fstart_at_strobe", o_fStart, (!e.err && model_start(e.data)) ? 0 : 1);
                    check_eq("fstop_at_strobe", o_fStop, (!e.err && model_stop(e.data)) ? 0 : 1);
                    if (e.gap != 0) check_eq("valid_gap", cyc - last_valid_cyc, e.gap);
                    if (o_RxValid) last_valid_cyc = cyc;
                end
            end
            if (!o_fStart) start_run++;
            else if (start_run != 0) begin
                check_eq("fstart_width", start_run, PULSE);
                start_pulses++;
                start_run = 0;
            end
            if (!o_fStop) stop_run++;
            else if (stop_run != 0) begin
                check_eq("fstop_width", stop_run, PULSE);
                stop_pulses++;
                stop_run = 0;
            end
        end
    end

    initial begin
        logic [7:0] b;
        i_Rst = 1'b0;
        i_Rx  = 1'b1;
        repeat (5) @(posedge i_Clk);
        #1;
        check_reset_outputs("reset");
        i_Rst = 1'b1;
        idle(20);

        send_frame(8'h53, 1'b1, 0);
        idle(20);
        send_frame(8'h74, 1'b1, 0);
        idle(20);
        send_frame(8'h41, 1'b1, 0);
        idle(20);

        // Framing error followed by a held-low line, then a normal stop command.
        send_frame(8'h53, 1'b0, 0);
        i_Rx = 1'b0;
        repeat (50) @(posedge i_Clk);
        #1;
        idle(30);
        send_frame(8'h54, 1'b1, 0);
        idle(20);

        // Short glitch must not produce any strobe.
        i_Rx = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1;
        idle(30);
        send_frame(8'h73, 1'b1, 0);
        idle(20);

        // Reset in the middle of data bit 4 of 0x53.
        b = 8'h53;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        i_Rx = b[4];
        repeat (5) @(posedge i_Clk);
        #3;
        i_Rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        last_good = 8'h00;
        i_Rx = 1'b1;
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst = 1'b1;
        idle(30);
        send_frame(8'h53, 1'b1, 0);
        idle(20);

        // Back-to-back frames with no idle gap.
        send_frame(8'h53, 1'b1, 0);
        send_frame(8'h53, 1'b1, CPB * 10);
        send_frame(8'h54, 1'b1, CPB * 10);
        idle(20);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge i_Clk);
        check_eq("scoreboard_drained", sb_q.size(), 0);
        check_eq("start_pulse_count", start_pulses, exp_start);
        check_eq("stop_pulse_count", stop_pulses, exp_stop);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
